// File: rtl/mac_seq_ctrl.sv
// Sequencer for the 8x8 multiply / 20-bit accumulate datapath: valid/ready intake, 3-stage
// pipeline tracking and frame hand-off. Optional early-frame flush: define MAC_SEQ_FLUSH_EN.
module mac_seq_ctrl #(
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned FRM_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic             out_ready,
`ifdef MAC_SEQ_FLUSH_EN
  input  logic             flush,
`endif
  output logic             valid_out,
  output logic             en_a,
  output logic             en_mult,
  output logic             en_f,
  output logic             clr_f,
  output logic             busy,
  output logic [FRM_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHold} state_e;

  localparam logic [CNT_W-1:0] FrameLen = CNT_W'(FRAME_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d, in_cnt_inc;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, acc_cnt_inc;
  logic [CNT_W-1:0] target;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             v1_q, v2_q;
  logic             accept;

`ifdef MAC_SEQ_FLUSH_EN
  // Products expected in the current frame; shortened by a flush.
  logic [CNT_W-1:0] target_q, target_d;
  assign target = target_q;
`else
  assign target = FrameLen;
`endif

  // Gated by reset so no sample is taken while the block is held in reset.
  assign ready_in    = reset && ((state_q == StIdle) || (state_q == StRun)) &&
                       (in_cnt_q < FrameLen);
  assign accept      = valid_in && ready_in;
  assign in_cnt_inc  = in_cnt_q + CNT_W'(accept);
  assign acc_cnt_inc = acc_cnt_q + CNT_W'(v2_q);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_inc;
    acc_cnt_d   = acc_cnt_inc;
    frame_cnt_d = frame_cnt_q;
`ifdef MAC_SEQ_FLUSH_EN
    target_d    = target_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (in_cnt_inc == target) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (in_cnt_inc == target) begin
          state_d = StDrain;
`ifdef MAC_SEQ_FLUSH_EN
        end else if (flush && (in_cnt_inc != '0)) begin
          state_d  = StDrain;
          target_d = in_cnt_inc;
`endif
        end
      end
      StDrain: begin
        // Compare against the post-update count so a flush after the pipeline has emptied
        // still terminates.
        if (acc_cnt_inc == target) begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d     = StIdle;
          in_cnt_d    = '0;
          acc_cnt_d   = '0;
          frame_cnt_d = frame_cnt_q + FRM_W'(1);
`ifdef MAC_SEQ_FLUSH_EN
          target_d    = FrameLen;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      in_cnt_q    <= '0;
      acc_cnt_q   <= '0;
      frame_cnt_q <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
`ifdef MAC_SEQ_FLUSH_EN
      target_q    <= FrameLen;
`endif
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      v1_q        <= accept;
      v2_q        <= v1_q;
`ifdef MAC_SEQ_FLUSH_EN
      target_q    <= target_d;
`endif
    end
  end

  assign en_a      = accept;
  assign en_mult   = v1_q;
  assign en_f      = v2_q;
  // First product of a frame overwrites the accumulator.
  assign clr_f     = v2_q && (acc_cnt_q == '0);
  assign valid_out = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed frames with a frame-result scoreboard.
module tb_mac_seq_ctrl;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       valid_in  = 1'b0;
  logic       out_ready = 1'b1;
  logic       ready_in, valid_out, en_a, en_mult, en_f, clr_f, busy;
  logic [7:0] frame_cnt;
`ifdef MAC_SEQ_FLUSH_EN
  logic       flush     = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  // Scoreboard: expected frame_cnt and en_f count for each result the DUT presents.
  logic [7:0] exp_fc_q[$];
  int         exp_nf_q[$];
  logic [7:0] exp_frames = 8'd0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .FRAME_LEN(4),
    .CNT_W    (5),
    .FRM_W    (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .ready_in (ready_in),
    .out_ready(out_ready),
`ifdef MAC_SEQ_FLUSH_EN
    .flush    (flush),
`endif
    .valid_out(valid_out),
    .en_a     (en_a),
    .en_mult  (en_mult),
    .en_f     (en_f),
    .clr_f    (clr_f),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts en_f/clr_f per frame and checks each presented result against the queue.
  initial begin : monitor
    int   cyc      = 0;
    int   last_acc = 0;
    int   nf       = 0;
    int   nclr     = 0;
    logic vo_prev  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        nf      = 0;
        nclr    = 0;
        vo_prev = 1'b0;
      end else begin
        if (en_a) last_acc = cyc;
        if (en_f) begin
          nf++;
          if (clr_f) nclr++;
          check("clr_f_on_first_en_f", int'(clr_f), int'(nf == 1));
        end
        if (valid_out) begin
          check("hold_quiet", int'({en_a, en_mult, en_f, ready_in}), 0);
          if (!vo_prev) begin
            if (exp_fc_q.size() == 0) begin
              check("unexpected_frame", 1, 0);
            end else begin
              check("frame_cnt_at_result", int'(frame_cnt), int'(exp_fc_q.pop_front()));
              check("en_f_pulses", nf, exp_nf_q.pop_front());
              check("clr_f_pulses", nclr, 1);
              check("result_latency", cyc - last_acc, 3);
            end
            nf   = 0;
            nclr = 0;
          end
        end
        vo_prev = valid_out;
      end
    end
  end

  task automatic send_frame(input int n, input bit toggle, input bit expect_result);
    int sent  = 0;
    int guard = 0;
    bit ph    = 1'b1;
    if (expect_result) begin
      exp_fc_q.push_back(exp_frames);
      exp_nf_q.push_back(n);
      exp_frames++;
    end
    while (sent < n && guard < 100) begin
      valid_in = toggle ? ph : 1'b1;
      @(negedge clk);
      if (valid_in && ready_in) sent++;
      tick();
      ph = ~ph;
      guard++;
    end
    valid_in = 1'b0;
    if (sent != n) check("send_timeout", sent, n);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || valid_out) && g < 60) begin
      tick();
      g++;
    end
    check("idle_reached", int'(busy || valid_out), 0);
  endtask

  // {en_a, en_mult, en_f, clr_f, valid_out, ready_in} per cycle for an unbroken 4-sample frame.
  logic [5:0] exp_tab [8] = '{6'b100001, 6'b110001, 6'b111101, 6'b111001,
                              6'b011000, 6'b001000, 6'b000010, 6'b000001};

  initial begin : stim
    int g;
    repeat (3) tick();
    check("reset_outputs",
          int'({ready_in, en_a, en_mult, en_f, clr_f, valid_out, busy}), 0);
    check("reset_frame_cnt", int'(frame_cnt), 0);
    reset = 1'b1;
    tick();
    check("idle_ready", int'(ready_in), 1);

    // Back-to-back frame, cycle-exact.
    exp_fc_q.push_back(exp_frames);
    exp_nf_q.push_back(4);
    exp_frames++;
    for (int i = 0; i < 8; i++) begin
      valid_in = (i < 4);
      @(negedge clk);
      check($sformatf("t1_cycle%0d", i),
            int'({en_a, en_mult, en_f, clr_f, valid_out, ready_in}), int'(exp_tab[i]));
      tick();
    end
    valid_in = 1'b0;
    check("t1_frame_cnt", int'(frame_cnt), 1);

    // Toggling valid_in.
    send_frame(4, 1'b1, 1'b1);
    wait_idle();

    // Downstream back-pressure for 5 cycles.
    out_ready = 1'b0;
    send_frame(4, 1'b0, 1'b1);
    g = 0;
    while (!valid_out && g < 20) begin
      tick();
      g++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", int'({valid_out, ready_in}), 2);
      check("bp_frame_cnt", int'(frame_cnt), 2);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(valid_out), 0);
    check("bp_release_frame_cnt", int'(frame_cnt), int'(exp_frames));
    tick();
    check("bp_ready_again", int'(ready_in), 1);

    // Reset in the middle of a frame.
    send_frame(2, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("midreset_outputs",
          int'({ready_in, en_a, en_mult, en_f, clr_f, valid_out, busy}), 0);
    check("midreset_frame_cnt", int'(frame_cnt), 0);
    exp_frames = 8'd0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midreset_no_result", int'(valid_out), 0);
    end
    send_frame(4, 1'b0, 1'b1);
    wait_idle();

    // 256 frames: frame_cnt wraps through 255 -> 0.
    for (int i = 0; i < 256; i++) begin
      send_frame(4, 1'b0, 1'b1);
    end
    wait_idle();
    check("wrap_frame_cnt", int'(frame_cnt), int'(exp_frames));

`ifdef MAC_SEQ_FLUSH_EN
    // Flush after two accepts yields a two-product frame.
    exp_fc_q.push_back(exp_frames);
    exp_nf_q.push_back(2);
    exp_frames++;
    valid_in = 1'b1;
    tick();
    tick();
    valid_in = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    check("flush_ready_dropped", int'(ready_in), 0);
    wait_idle();
    check("flush_frame_cnt", int'(frame_cnt), int'(exp_frames));
`endif

    repeat (3) tick();
    check("scoreboard_empty", exp_fc_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
